uart_lite_sched: RTL and testbench



---
 rtl/uart_lite_sched.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_lite_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lite_sched.sv
// uart_lite_sched: autonomous AXI-Lite master that drives a uart_lite peripheral.
// It writes CONTROL once after reset, then polls STATUS every POLL_DIV cycles.
// It moves received bytes to a valid/ready output and queued TX bytes to the UART.
module uart_lite_sched #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TX_DEPTH  = 4,
    parameter int          POLL_DIV  = 16,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] CTRL_INIT = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        m_awvalid_o,
    output logic [31:0] m_awaddr_o,
    output logic        m_wvalid_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    output logic        m_bready_o,
    output logic        m_arvalid_o,
    output logic [31:0] m_araddr_o,
    output logic        m_rready_o,
    input  logic        m_awready_i,
    input  logic        m_wready_i,
    input  logic        m_bvalid_i,
    input  logic [1:0]  m_bresp_i,
    input  logic        m_arready_i,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    output logic        busy_o,
    output logic        err_o
);
    localparam int AW   = $clog2(TX_DEPTH);
    localparam int PW   = AW + 1;
    localparam int CMAX = (TIMEOUT > POLL_DIV) ? TIMEOUT : POLL_DIV;
    localparam int CW   = $clog2(CMAX + 1) + 1;
    localparam logic [CW-1:0] TMO_LIM  = CW'(TIMEOUT);
    localparam logic [CW-1:0] POLL_LIM = CW'(POLL_DIV - 1);

    localparam logic [31:0] ADDR_RX     = BASE_ADDR + 32'h00;
    localparam logic [31:0] ADDR_TX     = BASE_ADDR + 32'h04;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h08;
    localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'h0C;

    localparam logic [2:0] S_INIT_W = 3'd0;
    localparam logic [2:0] S_INIT_B = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_IDLE   = 3'd3;
    localparam logic [2:0] S_ST_R   = 3'd4;
    localparam logic [2:0] S_RX_R   = 3'd5;
    localparam logic [2:0] S_TX_W   = 3'd6;
    localparam logic [2:0] S_TX_B   = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic          arvalid_q, arvalid_d, rready_q, rready_d;
    logic [31:0]   awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
    logic          rx_valid_q, rx_valid_d, err_q, err_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [TX_DEPTH];

    logic fifo_empty, fifo_full, push, pop, tmo;
    logic [7:0] fifo_head;
    logic unused_rdata;

    assign unused_rdata = ^m_rdata_i[31:8];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];
    assign tx_ready_o = !fifo_full && (state_q != S_INIT_W) && (state_q != S_INIT_B);
    assign push       = tx_valid_i && tx_ready_o;
    assign tmo        = (cnt_q == TMO_LIM);

    // Next-state logic for the sequencer, handshake outputs, RX register and FIFO pointers.
    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        araddr_d   = araddr_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        err_d      = err_q;
        pop        = 1'b0;

        if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

        case (state_q)
            S_INIT_W: begin
                if (!awvalid_q) begin
                    // First cycle out of reset: launch the CONTROL write.
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    bready_d  = 1'b1;
                    awaddr_d  = ADDR_CTRL;
                    wdata_d   = CTRL_INIT;
                end else if (m_awready_i && m_wready_i) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    state_d   = S_INIT_B;
                end else if (tmo) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_INIT_B, S_TX_B: begin
                if (m_bvalid_i) begin
                    bready_d = 1'b0;
                    if (m_bresp_i != 2'b00) err_d = 1'b1;
                    // The TX byte leaves the FIFO only once the UART acknowledged it.
                    if (state_q == S_TX_B) pop = 1'b1;
                    state_d = S_WAIT;
                end else if (tmo) begin
                    bready_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == POLL_LIM) state_d = S_IDLE;
            end
            S_IDLE: begin
                arvalid_d = 1'b1;
                rready_d  = 1'b1;
                araddr_d  = ADDR_STATUS;
                state_d   = S_ST_R;
            end
            S_ST_R, S_RX_R: begin
                if (arvalid_q && m_arready_i) arvalid_d = 1'b0;
                if (m_rvalid_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    if (m_rresp_i != 2'b00) err_d = 1'b1;
                    if (state_q == S_RX_R) begin
                        rx_data_d  = m_rdata_i[7:0];
                        rx_valid_d = 1'b1;
                        state_d    = S_WAIT;
                    end else if (m_rdata_i[0] && !rx_valid_q) begin
                        // Receive path wins over transmit to avoid RX overrun.
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        araddr_d  = ADDR_RX;
                        state_d   = S_RX_R;
                    end else if (m_rdata_i[2] && !fifo_empty) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        awaddr_d  = ADDR_TX;
                        wdata_d   = {24'b0, fifo_head};
                        state_d   = S_TX_W;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (tmo) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_TX_W: begin
                if (m_awready_i && m_wready_i) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    state_d   = S_TX_B;
                end else if (tmo) begin
                    // Abort leaves the byte queued so the next poll retries it.
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            default: state_d = S_INIT_W;
        endcase

        // One counter serves both the poll interval and the handshake watchdog.
        cnt_d    = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_INIT_W;
            cnt_q      <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            araddr_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            araddr_q   <= araddr_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= tx_data_i;
    end

    assign m_awvalid_o = awvalid_q;
    assign m_wvalid_o  = wvalid_q;
    assign m_bready_o  = bready_q;
    assign m_arvalid_o = arvalid_q;
    assign m_rready_o  = rready_q;
    assign m_awaddr_o  = awaddr_q;
    assign m_wdata_o   = wdata_q;
    assign m_araddr_o  = araddr_q;
    assign m_wstrb_o   = 4'hF;
    assign rx_valid_o  = rx_valid_q;
    assign rx_data_o   = rx_data_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_WAIT);
endmodule

// File: tb/tb_uart_lite_sched.sv
// Testbench for uart_lite_sched: AXI-Lite UART model plus write scoreboard.
module tb_uart_lite_sched;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int POLL = 4;
    localparam int TMO  = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0, rx_ready = 1'b0;
    logic        tx_ready, rx_valid, busy, err;
    logic [7:0]  rx_data;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] rdata;

    logic [7:0] status_val = 8'h00;
    logic [7:0] rx_byte = 8'h00;
    logic       aw_stall = 1'b0;

    int checks = 0, errors = 0;
    int cyc = 0;
    int rx_reads = 0;
    logic [31:0] obs_addr[$], obs_data[$], exp_addr[$], exp_data[$];
    logic [3:0]  obs_strb[$];
    int st_times[$];

    uart_lite_sched #(.BASE_ADDR(BASE), .TX_DEPTH(4), .POLL_DIV(POLL),
                      .TIMEOUT(TMO), .CTRL_INIT(32'h0000_0013)) dut (
        .clk_i(clk), .rst_i(rst),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .m_awvalid_o(awvalid), .m_awaddr_o(awaddr), .m_wvalid_o(wvalid),
        .m_wdata_o(wdata), .m_wstrb_o(wstrb), .m_bready_o(bready),
        .m_arvalid_o(arvalid), .m_araddr_o(araddr), .m_rready_o(rready),
        .m_awready_i(awready), .m_wready_i(wready), .m_bvalid_i(bvalid),
        .m_bresp_i(2'b00), .m_arready_i(arready), .m_rvalid_i(rvalid),
        .m_rdata_i(rdata), .m_rresp_i(2'b00),
        .busy_o(busy), .err_o(err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: ready two cycles after valid, response one cycle after the address handshake.
    logic [1:0]  wdly, rdly;
    logic        rpend;
    logic [31:0] raddr_l;
    always @(posedge clk) begin
        if (rst) begin
            awready <= 0; wready <= 0; bvalid <= 0; arready <= 0; rvalid <= 0;
            rdata <= 0; wdly <= 0; rdly <= 0; rpend <= 0; raddr_l <= 0;
        end else begin
            awready <= 0; wready <= 0; arready <= 0;
            if (awvalid && wvalid && !awready && !aw_stall) begin
                if (wdly == 2'd1) begin awready <= 1; wready <= 1; wdly <= 0; end
                else wdly <= wdly + 2'd1;
            end else if (!awvalid) wdly <= 0;
            if (awready && wready && awvalid && wvalid) begin
                bvalid <= 1;
                obs_addr.push_back(awaddr);
                obs_data.push_back(wdata);
                obs_strb.push_back(wstrb);
            end
            if (bvalid && bready) bvalid <= 0;
            if (arvalid && !arready && !rpend) begin
                if (rdly == 2'd1) begin arready <= 1; rdly <= 0; end
                else rdly <= rdly + 2'd1;
            end
            if (arready && arvalid) begin
                rpend <= 1;
                raddr_l <= araddr;
                if (araddr == BASE + 32'h8) st_times.push_back(cyc);
                if (araddr == BASE) rx_reads <= rx_reads + 1;
            end
            if (rpend && !rvalid) begin
                rvalid <= 1;
                rdata <= (raddr_l == BASE + 32'h8) ? {24'b0, status_val} : {24'b0, rx_byte};
            end
            if (rvalid && rready) begin rvalid <= 0; rpend <= 0; end
        end
    end

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int k = 0;
        while (obs_addr.size() < n && k < budget) begin @(negedge clk); k++; end
        ok = (obs_addr.size() >= n);
    endtask

    task automatic wait_status(input int n, input int budget, output bit ok);
        int target = st_times.size() + n;
        int k = 0;
        while (st_times.size() < target && k < budget) begin @(negedge clk); k++; end
        ok = (st_times.size() >= target);
    endtask

    task automatic push_byte(input logic [7:0] b, output bit acc);
        @(negedge clk);
        tx_data = b; tx_valid = 1'b1; acc = tx_ready;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_awvalid(output bit ok);
        int k = 0;
        while (!awvalid && k < 200) begin @(negedge clk); k++; end
        ok = awvalid;
    endtask

    // Pops expected writes and compares them against observed writes.
    task automatic check_writes(input string name, input int budget);
        bit ok;
        int n = exp_addr.size();
        wait_obs(n, budget, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, expected %0d", name, obs_addr.size(), n);
        end
        while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
            logic [31:0] ea = exp_addr.pop_front(), ed = exp_data.pop_front();
            logic [31:0] oa = obs_addr.pop_front(), od = obs_data.pop_front();
            logic [3:0]  os = obs_strb.pop_front();
            checks++;
            if (oa !== ea || od !== ed || os !== 4'hF) begin
                errors++;
                $display("FAIL %s: got addr %h data %h strb %h, expected addr %h data %h strb f",
                         name, oa, od, os, ea, ed);
            end
        end
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic test_reset;
        bit ok, saw_idle, saw_busy;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, rx_valid, err, tx_ready} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 00000000",
                     {awvalid, wvalid, bready, arvalid, rready, rx_valid, err, tx_ready});
        end
        checks++;
        if (awaddr !== 0 || wdata !== 0 || araddr !== 0 || rx_data !== 0 || wstrb !== 4'hF) begin
            errors++;
            $display("FAIL reset_data: got aw %h w %h ar %h rx %h strb %h expected zeros and strb f",
                     awaddr, wdata, araddr, rx_data, wstrb);
        end
        obs_addr.delete(); obs_data.delete(); obs_strb.delete();
        rst = 1'b0;
        exp_addr.push_back(BASE + 32'hC); exp_data.push_back(32'h13);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL init_flags: got busy %b tx_ready %b expected 1 0", busy, tx_ready);
        end
        check_writes("ctrl_write", 50);
        st_times.delete();
        saw_idle = 0; saw_busy = 0;
        for (int k = 0; k < 200 && st_times.size() < 3; k++) begin
            @(negedge clk);
            if (!busy) saw_idle = 1; else saw_busy = 1;
        end
        checks++;
        if (st_times.size() < 3) begin
            errors++;
            $display("FAIL poll_count: got %0d status reads expected 3", st_times.size());
        end else begin
            checks++;
            if (st_times[1] - st_times[0] != POLL + 6 || st_times[2] - st_times[1] != POLL + 6) begin
                errors++;
                $display("FAIL poll_period: got %0d,%0d expected %0d", st_times[1] - st_times[0],
                         st_times[2] - st_times[1], POLL + 6);
            end
        end
        checks++;
        if (!saw_idle || !saw_busy || err !== 1'b0) begin
            errors++;
            $display("FAIL busy_pulse: got idle %b busy %b err %b expected 1 1 0", saw_idle, saw_busy, err);
        end
    endtask

    task automatic test_tx_basic;
        bit acc0, acc1, ok;
        status_val = 8'h04;
        push_byte(8'hA5, acc0);
        push_byte(8'h3C, acc1);
        exp_addr.push_back(BASE + 32'h4); exp_data.push_back(32'hA5);
        exp_addr.push_back(BASE + 32'h4); exp_data.push_back(32'h3C);
        checks++;
        if (!acc0 || !acc1) begin
            errors++;
            $display("FAIL tx_ready_basic: got %b%b expected 11", acc0, acc1);
        end
        check_writes("tx_basic", 300);
        wait_status(3, 200, ok);
        checks++;
        if (!ok || obs_addr.size() != 0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_drained: got extra writes %0d tx_ready %b expected 0 1", obs_addr.size(), tx_ready);
        end
    endtask

    task automatic test_fifo_full;
        bit acc, all_acc, held;
        logic [7:0] bytes [5];
        bytes[0] = 8'h10; bytes[1] = 8'h20; bytes[2] = 8'h30; bytes[3] = 8'h40; bytes[4] = 8'h55;
        status_val = 8'h00;
        all_acc = 1;
        for (int i = 0; i < 4; i++) begin
            push_byte(bytes[i], acc);
            all_acc &= acc;
            exp_addr.push_back(BASE + 32'h4); exp_data.push_back({24'b0, bytes[i]});
        end
        checks++;
        if (!all_acc || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: got accepted %b tx_ready %b expected 1 0", all_acc, tx_ready);
        end
        tx_data = bytes[4]; tx_valid = 1'b1;
        held = 1;
        repeat (40) begin @(negedge clk); if (tx_ready) held = 0; end
        checks++;
        if (!held || obs_addr.size() != 0) begin
            errors++;
            $display("FAIL fifo_hold: got held %b writes %0d expected 1 0", held, obs_addr.size());
        end
        exp_addr.push_back(BASE + 32'h4); exp_data.push_back({24'b0, bytes[4]});
        status_val = 8'h04;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (tx_ready) break;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        check_writes("fifo_order", 600);
    endtask

    task automatic test_rx_priority;
        bit acc, ok;
        int base_rx;
        status_val = 8'h00; rx_ready = 1'b0;
        push_byte(8'h11, acc);
        wait_status(1, 100, ok);
        base_rx = rx_reads;
        rx_byte = 8'h5A; status_val = 8'h07;
        for (int k = 0; k < 100 && !rx_valid; k++) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h5A || obs_addr.size() != 0) begin
            errors++;
            $display("FAIL rx_first: got valid %b data %h writes %0d expected 1 5a 0",
                     rx_valid, rx_data, obs_addr.size());
        end
        exp_addr.push_back(BASE + 32'h4); exp_data.push_back(32'h11);
        check_writes("rx_then_tx", 200);
        wait_status(3, 200, ok);
        checks++;
        if (!ok || rx_reads - base_rx != 1 || rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
            errors++;
            $display("FAIL rx_hold: got rx_reads %0d valid %b data %h expected 1 1 5a",
                     rx_reads - base_rx, rx_valid, rx_data);
        end
        status_val = 8'h04;
        wait_status(2, 100, ok);
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_pop: got valid %b expected 0", rx_valid);
        end
    endtask

    task automatic test_timeout;
        bit acc, ok;
        int hi = 0;
        status_val = 8'h04; aw_stall = 1'b1;
        push_byte(8'h77, acc);
        wait_awvalid(ok);
        for (int k = 0; k < 3 * TMO && !err; k++) begin
            if (awvalid) hi++;
            @(negedge clk);
        end
        checks++;
        if (!ok || err !== 1'b1 || hi < TMO || hi > TMO + 2) begin
            errors++;
            $display("FAIL timeout_err: got err %b awvalid cycles %0d expected 1 and %0d..%0d",
                     err, hi, TMO, TMO + 2);
        end
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0 || obs_addr.size() != 0) begin
            errors++;
            $display("FAIL timeout_drop: got valids %b writes %0d expected 00000 0",
                     {awvalid, wvalid, bready, arvalid, rready}, obs_addr.size());
        end
        aw_stall = 1'b0;
        exp_addr.push_back(BASE + 32'h4); exp_data.push_back(32'h77);
        check_writes("timeout_retry", 300);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_reset_mid;
        bit acc, ok;
        status_val = 8'h04; aw_stall = 1'b1;
        push_byte(8'h99, acc);
        wait_awvalid(ok);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (!ok || {awvalid, wvalid, bready, arvalid, rready, rx_valid, err, tx_ready} !== 8'b0) begin
            errors++;
            $display("FAIL reset_mid: got %b expected 00000000",
                     {awvalid, wvalid, bready, arvalid, rready, rx_valid, err, tx_ready});
        end
        @(negedge clk); rst = 1'b0; aw_stall = 1'b0;
        exp_addr.push_back(BASE + 32'hC); exp_data.push_back(32'h13);
        check_writes("reset_ctrl", 100);
        wait_status(3, 200, ok);
        checks++;
        if (!ok || obs_addr.size() != 0) begin
            errors++;
            $display("FAIL reset_fifo_empty: got writes %0d polls_ok %b expected 0 1", obs_addr.size(), ok);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_fifo_full();
        test_rx_priority();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
